adc_capture_ctrl: RTL and testbench

- Sequences the dual-channel 8-bit ADC front end: power-down control, wake-up settling, trigger arming and frame capture.
- Packs the channel A and B samples into 16-bit words.
- Emits fixed-length AXI4-Stream frames through a small output FIFO.
- Sits between the ADC input registers (already in the sample-clock domain) and the downstream AXI4-Stream consumer.

---
 rtl/adc_capture_ctrl_if.sv | 10 +
 rtl/adc_capture_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_capture_ctrl_if.sv
// AXI4-Stream link carrying packed {channel B, channel A} sample words.
interface adc_capture_ctrl_if;
  logic [15:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/adc_capture_ctrl.sv
// Dual-channel ADC sequencer: power-down/wake control, trigger arming,
// fixed-length frame capture and a small FWFT output FIFO onto AXI4-Stream.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_OFF     | ADC powered down; re-enable honoured after PDN_CYCLES here
// S_PWRUP   | ADC powered, waiting WAKE_CYCLES for the front end to settle
// S_IDLE    | settled, waiting for cfg_start
// S_ARMED   | waiting for immediate start or threshold crossing on A
// S_CAPTURE | pushing one word per cycle until frame_len accepted
// S_DRAIN   | frame complete, waiting for the FIFO to empty
module adc_capture_ctrl #(
  parameter int WAKE_CYCLES = 64,
  parameter int PDN_CYCLES  = 16,
  parameter int LEN_W       = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         adc_data_a,
  input  logic [7:0]         adc_data_b,
  output logic               adc_pdn,
  input  logic               cfg_enable,
  input  logic               cfg_start,
  input  logic               cfg_trig_mode,
  input  logic [7:0]         cfg_threshold,
  input  logic [LEN_W-1:0]   cfg_frame_len,
  adc_capture_ctrl_if.master m_axis,
  output logic               adc_ready,
  output logic               busy,
  output logic               overflow
);

  localparam int TMR_MAX = (WAKE_CYCLES > PDN_CYCLES) ? WAKE_CYCLES : PDN_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  typedef enum logic [2:0] {
    S_OFF,
    S_PWRUP,
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DRAIN
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [TMR_W-1:0]   tmr;
  logic [LEN_W-1:0]   words_left;
  logic               trig_mode_q;
  logic [7:0]         thr_q;
  logic [7:0]         prev_a;
  logic               arm_vld;
  logic               overflow_q;
  logic               start_ok;

  logic [16:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nxt;
  logic               empty_q;
  logic               full_q;

  logic               trig_hit;
  logic               push_try;
  logic               push_ok;
  logic               pop;
  logic               last_word;

  // prev_a is only meaningful once we have spent a full cycle in ARMED
  assign trig_hit  = arm_vld && (prev_a < thr_q) && (adc_data_a >= thr_q);
  assign push_try  = (state == S_CAPTURE) ||
                     ((state == S_ARMED) && cfg_enable && trig_mode_q && trig_hit);
  assign pop       = m_axis.tvalid && m_axis.tready;
  assign push_ok   = push_try && (!full_q || pop);
  assign last_word = (words_left == LEN_W'(1));
  assign start_ok  = cfg_start && (cfg_frame_len != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_OFF;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    adc_pdn   = 1'b0;
    adc_ready = 1'b0;
    busy      = 1'b0;
    case (state)
      S_OFF: begin
        adc_pdn = 1'b1;
        if (cfg_enable && (tmr == '0)) state_nxt = S_PWRUP;
      end
      S_PWRUP: begin
        if (!cfg_enable)       state_nxt = S_OFF;
        else if (tmr == '0)    state_nxt = S_IDLE;
      end
      S_IDLE: begin
        adc_ready = 1'b1;
        if (!cfg_enable)       state_nxt = S_OFF;
        else if (start_ok)     state_nxt = S_ARMED;
      end
      S_ARMED: begin
        adc_ready = 1'b1;
        busy      = 1'b1;
        if (!cfg_enable)       state_nxt = S_OFF;
        else if (!trig_mode_q) state_nxt = S_CAPTURE;
        else if (trig_hit)     state_nxt = (push_ok && last_word) ? S_DRAIN : S_CAPTURE;
      end
      S_CAPTURE: begin
        adc_ready = 1'b1;
        busy      = 1'b1;
        if (push_ok && last_word) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        adc_ready = 1'b1;
        busy      = 1'b1;
        // a disable seen during the frame takes effect only here
        if (empty_q) state_nxt = cfg_enable ? S_IDLE : S_OFF;
      end
      default: begin
        adc_pdn   = 1'b1;
        state_nxt = S_OFF;
      end
    endcase
  end

  // Shared settle/hold-off down-counter, loaded on entry to OFF or PWRUP.
  // Reset leaves it at zero so the first power-up is not delayed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if ((state_nxt == S_OFF) && (state != S_OFF)) begin
      tmr <= TMR_W'(PDN_CYCLES - 1);
    end else if ((state_nxt == S_PWRUP) && (state != S_PWRUP)) begin
      tmr <= TMR_W'(WAKE_CYCLES - 1);
    end else if ((tmr != '0) && ((state == S_OFF) || (state == S_PWRUP))) begin
      tmr <= tmr - TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_left  <= '0;
      trig_mode_q <= 1'b0;
      thr_q       <= '0;
      overflow_q  <= 1'b0;
      prev_a      <= '0;
      arm_vld     <= 1'b0;
    end else begin
      prev_a  <= adc_data_a;
      arm_vld <= (state == S_ARMED);
      if ((state == S_IDLE) && cfg_enable && start_ok) begin
        words_left  <= cfg_frame_len;
        trig_mode_q <= cfg_trig_mode;
        thr_q       <= cfg_threshold;
        overflow_q  <= 1'b0;
      end else begin
        if (push_ok) words_left <= words_left - LEN_W'(1);
        if (push_try && !push_ok) overflow_q <= 1'b1;
      end
    end
  end

  assign overflow = overflow_q;

  // FIFO storage carries {B, A, last}; it needs no reset since tvalid gates it
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {adc_data_b, adc_data_a, last_word};
  end

  assign count_nxt = count + CNT_W'(push_ok) - CNT_W'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count_nxt;
      empty_q <= (count_nxt == '0);
      full_q  <= (count_nxt == CNT_W'(FIFO_DEPTH));
    end
  end

  assign m_axis.tvalid = !empty_q;
  assign m_axis.tdata  = m_axis.tvalid ? mem[rd_ptr][16:1] : 16'h0000;
  assign m_axis.tlast  = m_axis.tvalid && mem[rd_ptr][0];

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: wake timing, immediate and threshold
// capture, backpressure/overflow, deferred disable, ignored starts, reset.
module tb_adc_capture_ctrl;

  logic        clk;
  logic        rst_n;
  logic [7:0]  adc_data_a;
  logic [7:0]  adc_data_b;
  logic        adc_pdn;
  logic        cfg_enable;
  logic        cfg_start;
  logic        cfg_trig_mode;
  logic [7:0]  cfg_threshold;
  logic [15:0] cfg_frame_len;
  logic        adc_ready;
  logic        busy;
  logic        overflow;

  adc_capture_ctrl_if axis ();

  adc_capture_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .adc_data_a    (adc_data_a),
    .adc_data_b    (adc_data_b),
    .adc_pdn       (adc_pdn),
    .cfg_enable    (cfg_enable),
    .cfg_start     (cfg_start),
    .cfg_trig_mode (cfg_trig_mode),
    .cfg_threshold (cfg_threshold),
    .cfg_frame_len (cfg_frame_len),
    .m_axis        (axis),
    .adc_ready     (adc_ready),
    .busy          (busy),
    .overflow      (overflow)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [16:0] exp_q[$];
  logic [7:0]  a_seq [64];
  logic [7:0]  b_seq [64];
  logic        ovf_exp;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Stream monitor: scoreboard pop on handshake, hold-stability under backpressure
  initial begin
    logic        hold;
    logic [16:0] hold_w;
    logic [16:0] e;
    hold   = 1'b0;
    hold_w = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_tvalid", 32'(axis.tvalid), 32'd1);
          chk("hold_word", 32'({axis.tdata, axis.tlast}), 32'(hold_w));
        end
        if (axis.tvalid && axis.tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 32'({axis.tdata, axis.tlast}), 32'h1ffff);
          end else begin
            e = exp_q.pop_front();
            chk("beat_tdata", 32'(axis.tdata), 32'(e[16:1]));
            chk("beat_tlast", 32'(axis.tlast), 32'(e[0]));
          end
        end
        hold   = axis.tvalid && !axis.tready;
        hold_w = {axis.tdata, axis.tlast};
      end
    end
  end

  // Called at the negedge of the first PWRUP cycle; adc_ready must rise 64 cycles later.
  task automatic check_wake();
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      chk("wake_ready", 32'(adc_ready), 32'(n == 64));
    end
    chk("wake_busy", 32'(busy), 32'd0);
  endtask

  // Arms one frame and drives a_seq/b_seq from the first ARMED cycle onward,
  // modelling trigger, FIFO occupancy and drops to fill the scoreboard.
  task automatic run_frame(input int len, input bit mode, input logic [7:0] thr,
                           input int lo_start, input int lo_len,
                           input int dis_at, input int restart_at);
    int         occ;
    int         cnt;
    int         i;
    bit         cap;
    bit         first;
    bit         rdy;
    bit         pop;
    bit         acc;
    bit         try_push;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] prev;
    occ = 0; cnt = 0; i = 0; cap = 0; first = 1; prev = '0;
    ovf_exp = 1'b0;
    @(posedge clk); #1;
    cfg_start     = 1'b1;
    cfg_frame_len = 16'(len);
    cfg_trig_mode = mode;
    cfg_threshold = thr;
    adc_data_a    = 8'h10;
    adc_data_b    = 8'h00;
    axis.tready   = 1'b1;
    while (cnt < len && i < 200) begin
      @(posedge clk); #1;
      cfg_start = (i == restart_at);
      if (i == dis_at) cfg_enable = 1'b0;
      a = a_seq[i % 64];
      b = b_seq[i % 64];
      adc_data_a = a;
      adc_data_b = b;
      rdy = !(i >= lo_start && i < lo_start + lo_len);
      axis.tready = rdy;
      pop = rdy && (occ > 0);
      try_push = cap;
      if (!cap) begin
        if (!mode) cap = 1;
        else if (!first && prev < thr && a >= thr) begin
          try_push = 1;
          cap = 1;
        end
        first = 0;
      end
      acc = 0;
      if (try_push) begin
        acc = (occ < 4) || pop;
        if (acc) begin
          cnt++;
          exp_q.push_back({b, a, cnt == len});
        end else begin
          ovf_exp = 1'b1;
        end
      end
      occ = occ + int'(acc) - int'(pop);
      prev = a;
      i++;
    end
    @(posedge clk); #1;
    cfg_start   = 1'b0;
    axis.tready = 1'b1;
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(negedge clk);
    chk("drain_done", 32'(exp_q.size()), 32'd0);
    chk("pdn_in_frame", 32'(adc_pdn), 32'd0);
    for (int k = 0; k < 8 && busy; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("busy_after_frame", 32'(busy), 32'd0);
    chk("overflow", 32'(overflow), 32'(ovf_exp));
  endtask

  initial begin
    rst_n = 1'b1; cfg_enable = 1'b1; cfg_start = 1'b0; cfg_trig_mode = 1'b0;
    cfg_threshold = '0; cfg_frame_len = '0; adc_data_a = '0; adc_data_b = '0;
    axis.tready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_pdn", 32'(adc_pdn), 32'd1);
    chk("rst_tvalid", 32'(axis.tvalid), 32'd0);
    chk("rst_tdata", 32'(axis.tdata), 32'd0);
    chk("rst_tlast", 32'(axis.tlast), 32'd0);
    chk("rst_ready", 32'(adc_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // power-up after reset
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("pwr_pdn_before", 32'(adc_pdn), 32'd1);
    @(negedge clk);
    chk("pwr_pdn_fall", 32'(adc_pdn), 32'd0);
    chk("pwr_ready_low", 32'(adc_ready), 32'd0);
    check_wake();

    // immediate capture, ramps
    for (int i = 0; i < 64; i++) begin
      a_seq[i] = 8'(i - 1);
      b_seq[i] = 8'(15 + i);
    end
    run_frame(8, 1'b0, 8'h00, 0, 0, -1, -1);

    // threshold trigger from below
    for (int i = 0; i < 64; i++) begin
      a_seq[i] = 8'(8'h70 + i);
      b_seq[i] = 8'(i);
    end
    run_frame(4, 1'b1, 8'h80, 0, 0, -1, -1);

    // threshold trigger starting above: must dip below and cross again
    for (int i = 0; i < 64; i++) begin
      a_seq[i] = 8'(8'h81 + i - 7);
      b_seq[i] = 8'(8'h20 + i);
    end
    a_seq[0] = 8'h90; a_seq[1] = 8'hA0; a_seq[2] = 8'h85; a_seq[3] = 8'h70;
    a_seq[4] = 8'h60; a_seq[5] = 8'h7F; a_seq[6] = 8'h80;
    run_frame(4, 1'b1, 8'h80, 0, 0, -1, -1);

    // backpressure for 10 cycles, overflow, ignored start while busy
    for (int i = 0; i < 64; i++) begin
      a_seq[i] = 8'(i);
      b_seq[i] = 8'(8'h40 + i);
    end
    run_frame(16, 1'b0, 8'h00, 1, 10, -1, 5);

    // disable mid-capture, frame completes, then hold-off before re-enable
    for (int i = 0; i < 64; i++) begin
      a_seq[i] = 8'(8'hA0 + i);
      b_seq[i] = 8'(8'h80 + i);
    end
    run_frame(8, 1'b0, 8'h00, 0, 0, 3, -1);
    chk("off_pdn_first", 32'(adc_pdn), 32'd1);
    chk("off_ready", 32'(adc_ready), 32'd0);
    for (int c = 2; c <= 17; c++) begin
      @(posedge clk); #1;
      if (c == 5) cfg_enable = 1'b1;
      @(negedge clk);
      chk("off_holdoff_pdn", 32'(adc_pdn), 32'(c <= 16));
    end
    check_wake();

    // start with zero length is ignored
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_frame_len = 16'd0; cfg_trig_mode = 1'b0;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("zero_len_busy", 32'(busy), 32'd0);
      chk("zero_len_tvalid", 32'(axis.tvalid), 32'd0);
    end

    // reset mid-frame with a full FIFO and overflow set
    @(posedge clk); #1;
    axis.tready = 1'b0;
    cfg_start = 1'b1; cfg_frame_len = 16'd8; cfg_trig_mode = 1'b0;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_tvalid", 32'(axis.tvalid), 32'd1);
    chk("pre_rst_overflow", 32'(overflow), 32'd1);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_pdn", 32'(adc_pdn), 32'd1);
    chk("midrst_tvalid", 32'(axis.tvalid), 32'd0);
    chk("midrst_tdata", 32'(axis.tdata), 32'd0);
    chk("midrst_tlast", 32'(axis.tlast), 32'd0);
    chk("midrst_ready", 32'(adc_ready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_overflow", 32'(overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
